// File: rtl/cgra_iteration_tracker.sv
// cgra_iteration_tracker: array-side completion detector.
// Counts completed schedule iterations from pe_enable/context_pc/global_stall,
// waits out a pipeline-drain interval, then holds array_done_o until the
// control unit drops pe_enable. It also flags PC sequencing errors (sticky).
// Optional build macro CGRA_ITER_STALL_STATS_EN enables the stall-cycle
// counter. Without it, stall_count_o is tied to zero.
//
//   state | meaning
//   IDLE  | waiting for pe_enable with the array out of soft reset
//   RUN   | schedule executing; beats checked and iterations counted
//   DRAIN | final iteration issued; counting unstalled drain cycles
//   DONE  | array_done_o high until pe_enable drops
module cgra_iteration_tracker #(
  parameter int CONTEXT_DEPTH = 16,
  parameter int PC_WIDTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pe_enable_i,
  input  logic                pe_reset_n_i,
  input  logic                global_stall_i,
  input  logic [PC_WIDTH-1:0] context_pc_i,
  input  logic [PC_WIDTH-1:0] cfg_last_pc_i,
  input  logic [31:0]         cfg_iterations_i,
  input  logic [7:0]          cfg_drain_cycles_i,
  output logic                array_done_o,
  output logic [31:0]         iter_count_o,
  output logic                pc_error_o,
  output logic [31:0]         stall_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   exp_pc_q, exp_pc_d;
  logic [7:0]            drain_q, drain_d;
  logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
  logic [31:0]           iter_cfg_q, iter_cfg_d;
  logic [7:0]            drain_cfg_q, drain_cfg_d;
  logic [31:0]           iter_q, iter_d;
  logic                  err_q, err_d;

  // The start cycle runs as a RUN cycle against live cfg and freshly
  // cleared counters, so every RUN-path input is muxed on start.
  logic                  start;
  logic [PC_WIDTH-1:0]   eff_last_pc, eff_exp_pc, pc_next;
  logic [31:0]           eff_iter_cfg, eff_iter, iter_inc;
  logic [7:0]            eff_drain_cfg;
  logic                  eff_err, beat, end_beat, last_pc_ok;

  assign start         = (state_q == IDLE) && pe_enable_i && pe_reset_n_i;
  assign eff_last_pc   = start ? cfg_last_pc_i      : last_pc_q;
  assign eff_iter_cfg  = start ? cfg_iterations_i   : iter_cfg_q;
  assign eff_drain_cfg = start ? cfg_drain_cycles_i : drain_cfg_q;
  assign eff_exp_pc    = start ? '0                 : exp_pc_q;
  assign eff_iter      = start ? '0                 : iter_q;
  assign eff_err       = start ? 1'b0               : err_q;

  assign beat     = pe_enable_i && pe_reset_n_i && !global_stall_i;
  assign end_beat = beat && last_pc_ok && (context_pc_i == eff_last_pc);
  assign iter_inc = (eff_iter == 32'hFFFF_FFFF) ? eff_iter : eff_iter + 32'd1;
  assign pc_next  = (context_pc_i == PC_WIDTH'(CONTEXT_DEPTH - 1)) ? '0
                                                                   : context_pc_i + PC_WIDTH'(1);

  // An out-of-range last-slot setting can never match, so the run never completes.
  if (CONTEXT_DEPTH >= (1 << PC_WIDTH)) begin : g_full_range
    assign last_pc_ok = 1'b1;
  end else begin : g_part_range
    assign last_pc_ok = (eff_last_pc < PC_WIDTH'(CONTEXT_DEPTH));
  end

  // State and datapath register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_pc_q    <= '0;
      drain_q     <= '0;
      last_pc_q   <= '0;
      iter_cfg_q  <= '0;
      drain_cfg_q <= '0;
      iter_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_pc_q    <= exp_pc_d;
      drain_q     <= drain_d;
      last_pc_q   <= last_pc_d;
      iter_cfg_q  <= iter_cfg_d;
      drain_cfg_q <= drain_cfg_d;
      iter_q      <= iter_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    exp_pc_d    = exp_pc_q;
    drain_d     = drain_q;
    last_pc_d   = last_pc_q;
    iter_cfg_d  = iter_cfg_q;
    drain_cfg_d = drain_cfg_q;
    iter_d      = iter_q;
    err_d       = err_q;
    if (!pe_reset_n_i) begin
      state_d     = IDLE;
      exp_pc_d    = '0;
      drain_d     = '0;
      last_pc_d   = '0;
      iter_cfg_d  = '0;
      drain_cfg_d = '0;
      iter_d      = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (!pe_enable_i) begin
            state_d = IDLE;
          end else begin
            state_d     = RUN;
            last_pc_d   = eff_last_pc;
            iter_cfg_d  = eff_iter_cfg;
            drain_cfg_d = eff_drain_cfg;
            exp_pc_d    = eff_exp_pc;
            iter_d      = eff_iter;
            err_d       = eff_err;
            if (beat) begin
              if (context_pc_i != eff_exp_pc) err_d = 1'b1;
              exp_pc_d = pc_next;
            end
            if (end_beat) begin
              iter_d = iter_inc;
              if ((eff_iter_cfg != 32'd0) && (iter_inc == eff_iter_cfg)) begin
                if (eff_drain_cfg == 8'd0) begin
                  state_d = DONE;
                end else begin
                  state_d = DRAIN;
                  drain_d = eff_drain_cfg - 8'd1;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (!pe_enable_i) begin
            state_d = IDLE;
          end else if (!global_stall_i) begin
            if (drain_q == 8'd0) state_d = DONE;
            else                 drain_d = drain_q - 8'd1;
          end
        end
        DONE: begin
          if (!pe_enable_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign array_done_o = (state_q == DONE);
  assign iter_count_o = iter_q;
  assign pc_error_o   = err_q;

`ifdef CGRA_ITER_STALL_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of frozen cycles while the schedule is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pe_reset_n_i || start) begin
      stall_q <= '0;
    end else if (((state_q == RUN) || (state_q == DRAIN)) && global_stall_i &&
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_cgra_iteration_tracker.sv
// Directed bench for cgra_iteration_tracker. Cycle c is the clock period in
// which inputs for c are applied. Outputs observed in cycle c reflect state
// after the edge that consumed cycle c-1.
module tb_cgra_iteration_tracker;

  logic        clk;
  logic        rst;
  logic        pe_enable_i;
  logic        pe_reset_n_i;
  logic        global_stall_i;
  logic [3:0]  context_pc_i;
  logic [3:0]  cfg_last_pc_i;
  logic [31:0] cfg_iterations_i;
  logic [7:0]  cfg_drain_cycles_i;
  logic        array_done_o;
  logic [31:0] iter_count_o;
  logic        pc_error_o;
  logic [31:0] stall_count_o;

  int npass;
  int ntotal;
  int cyc;
  logic        done_hist [0:127];
  logic        err_hist  [0:127];
  logic [31:0] iter_hist [0:127];

  cgra_iteration_tracker #(.CONTEXT_DEPTH(16), .PC_WIDTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .pe_enable_i        (pe_enable_i),
    .pe_reset_n_i       (pe_reset_n_i),
    .global_stall_i     (global_stall_i),
    .context_pc_i       (context_pc_i),
    .cfg_last_pc_i      (cfg_last_pc_i),
    .cfg_iterations_i   (cfg_iterations_i),
    .cfg_drain_cycles_i (cfg_drain_cycles_i),
    .array_done_o       (array_done_o),
    .iter_count_o       (iter_count_o),
    .pc_error_o         (pc_error_o),
    .stall_count_o      (stall_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    pe_enable_i    = 1'b0;
    pe_reset_n_i   = 1'b1;
    global_stall_i = 1'b0;
    context_pc_i   = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 128; i++) begin
      done_hist[i] = 1'b0;
      err_hist[i]  = 1'b0;
      iter_hist[i] = 32'd0;
    end
  endtask

  // Record this cycle's outputs, then apply this cycle's inputs.
  task automatic tick(input logic en, input logic rn, input logic st, input logic [3:0] pc);
    @(negedge clk);
    if (cyc < 128) begin
      done_hist[cyc] = array_done_o;
      err_hist[cyc]  = pc_error_o;
      iter_hist[cyc] = iter_count_o;
    end
    pe_enable_i    = en;
    pe_reset_n_i   = rn;
    global_stall_i = st;
    context_pc_i   = pc;
    cyc++;
  endtask

  // Well-formed PC stream; two stall windows; enable dropped from cycle drop;
  // cfg inputs scrambled at cycle chg to show the shadows are in use.
  task automatic run_scn(input int n, input int drop, input int s0, input int s1,
                         input int d0, input int d1, input int chg);
    int beat;
    logic st;
    beat = 0;
    for (int c = 0; c < n; c++) begin
      if (c == chg) begin
        cfg_last_pc_i      = 4'd7;
        cfg_iterations_i   = 32'd5;
        cfg_drain_cycles_i = 8'd0;
      end
      st = ((c >= s0) && (c <= s1)) || ((c >= d0) && (c <= d1));
      tick(c < drop, 1'b1, st, 4'(beat % 16));
      if ((c < drop) && !st) beat++;
    end
  endtask

  function automatic logic any_done(input int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r = r | done_hist[i];
    return r;
  endfunction

  initial begin
    logic [31:0] exp_stall;
    npass = 0;
    ntotal = 0;
    cyc = 0;
    rst = 1'b1;
    pe_enable_i = 1'b0;
    pe_reset_n_i = 1'b1;
    global_stall_i = 1'b0;
    context_pc_i = 4'd0;
    cfg_last_pc_i = 4'd15;
    cfg_iterations_i = 32'd2;
    cfg_drain_cycles_i = 8'd3;

    // Scenario 1: two full iterations, drain 3, cfg scrambled mid-run.
    do_reset();
    chk("rst_done", {31'd0, array_done_o}, 32'd0);
    chk("rst_iter", iter_count_o, 32'd0);
    chk("rst_err", {31'd0, pc_error_o}, 32'd0);
    chk("rst_stall", stall_count_o, 32'd0);
    run_scn(40, 37, -1, -1, -1, -1, 5);
    chk("s1_iter_c16", iter_hist[16], 32'd1);
    chk("s1_done_c34", {31'd0, done_hist[34]}, 32'd0);
    chk("s1_done_c35", {31'd0, done_hist[35]}, 32'd1);
    chk("s1_done_c37", {31'd0, done_hist[37]}, 32'd1);
    chk("s1_done_c38", {31'd0, done_hist[38]}, 32'd0);
    chk("s1_iter", iter_count_o, 32'd2);
    chk("s1_err", {31'd0, pc_error_o}, 32'd0);

    // Scenario 2: stalls at 10-13 in RUN and 36-37 in DRAIN.
    cfg_last_pc_i = 4'd15; cfg_iterations_i = 32'd2; cfg_drain_cycles_i = 8'd3;
    do_reset();
    run_scn(45, 44, 10, 13, 36, 37, -1);
    chk("s2_done_c40", {31'd0, done_hist[40]}, 32'd0);
    chk("s2_done_c41", {31'd0, done_hist[41]}, 32'd1);
    chk("s2_iter", iter_count_o, 32'd2);
`ifdef CGRA_ITER_STALL_STATS_EN
    exp_stall = 32'd6;
`else
    exp_stall = 32'd0;
`endif
    chk("s2_stall", stall_count_o, exp_stall);

    // Scenario 3: PC 0,1,3 with last_pc 3, one iteration, no drain.
    cfg_last_pc_i = 4'd3; cfg_iterations_i = 32'd1; cfg_drain_cycles_i = 8'd0;
    do_reset();
    tick(1, 1, 0, 4'd0);
    tick(1, 1, 0, 4'd1);
    tick(1, 1, 0, 4'd3);
    tick(1, 1, 0, 4'd0);
    tick(0, 1, 0, 4'd0);
    tick(0, 1, 0, 4'd0);
    tick(0, 1, 0, 4'd0);
    tick(1, 1, 0, 4'd0);
    tick(1, 1, 0, 4'd1);
    tick(1, 1, 0, 4'd2);
    chk("s3_err_c2", {31'd0, err_hist[2]}, 32'd0);
    chk("s3_err_c3", {31'd0, err_hist[3]}, 32'd1);
    chk("s3_done_c3", {31'd0, done_hist[3]}, 32'd1);
    chk("s3_done_c5", {31'd0, done_hist[5]}, 32'd0);
    chk("s3_err_held", {31'd0, err_hist[6]}, 32'd1);
    chk("s3_iter_held", iter_hist[6], 32'd1);
    chk("s3_err_restart", {31'd0, err_hist[8]}, 32'd0);
    chk("s3_iter_restart", iter_hist[8], 32'd0);

    // Scenario 4: soft reset while draining; cycle 5 carries a bad PC.
    cfg_last_pc_i = 4'd15; cfg_iterations_i = 32'd1; cfg_drain_cycles_i = 8'd10;
    do_reset();
    for (int c = 0; c < 18; c++) tick(1, 1, 0, (c == 5) ? 4'd7 : 4'(c));
    tick(1, 0, 0, 4'd0);
    for (int c = 19; c < 31; c++) tick(0, 1, 0, 4'd0);
    chk("s4_iter_c17", iter_hist[17], 32'd1);
    chk("s4_err_c17", {31'd0, err_hist[17]}, 32'd1);
    chk("s4_iter_c19", iter_hist[19], 32'd0);
    chk("s4_err_c19", {31'd0, err_hist[19]}, 32'd0);
    chk("s4_no_done", {31'd0, any_done(31)}, 32'd0);

    // Scenario 5: free-run (iterations 0) for 100 cycles, then drop enable.
    cfg_last_pc_i = 4'd15; cfg_iterations_i = 32'd0; cfg_drain_cycles_i = 8'd3;
    do_reset();
    run_scn(106, 100, -1, -1, -1, -1, -1);
    chk("s5_iter_c95", iter_hist[95], 32'd5);
    chk("s5_iter_c96", iter_hist[96], 32'd6);
    chk("s5_iter_held", iter_count_o, 32'd6);
    chk("s5_no_done", {31'd0, any_done(106)}, 32'd0);

    // Scenario 6: one iteration ending on PC 3 with no drain, then async reset in DONE.
    cfg_last_pc_i = 4'd3; cfg_iterations_i = 32'd1; cfg_drain_cycles_i = 8'd0;
    do_reset();
    run_scn(7, 100, -1, -1, -1, -1, -1);
    chk("s6_done_c3", {31'd0, done_hist[3]}, 32'd0);
    chk("s6_done_c4", {31'd0, done_hist[4]}, 32'd1);
    chk("s6_done_c6", {31'd0, done_hist[6]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_done", {31'd0, array_done_o}, 32'd0);
    chk("s6_async_iter", iter_count_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
